retire_monitor: RTL and testbench

Hardware run-control and retirement monitor instantiated beside `cpu_top`, downstream of the writeback stage. Consumes the per-cycle retire stream and the IF-stage PC, counts cycles and retired instructions, and detects program halt (fixed halt PC), run timeout, and fetch stall. Results are registered for benches and debug logic; CPI is computed off-block as `cycle_count / instret`.

---
 rtl/retire_monitor.sv | 133 +++++++++++++
 tb/tb_retire_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/retire_monitor.sv
// rtl/retire_monitor.sv - run-control and retirement monitor beside cpu_top
// Optional stall watchdog: define RETIRE_MON_STALL_WDT_EN.
module retire_monitor #(
  parameter logic [31:0] HALT_PC     = 32'h000A00BC,
  parameter int unsigned MAX_CYCLES  = 500,
  parameter int unsigned STALL_LIMIT = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] if_pc,
  input  logic        retire_valid,
  input  logic [31:0] retire_pc,
  input  logic        retire_we,
  input  logic [4:0]  retire_rd,
  input  logic [31:0] retire_data,
  output logic [2:0]  state,
  output logic [31:0] cycle_count,
  output logic [31:0] instret,
  output logic [31:0] last_retire_pc,
  output logic [4:0]  last_rd,
  output logic [31:0] last_data,
  output logic        done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_HALTED  = 3'd2;
  localparam logic [2:0] S_TIMEOUT = 3'd3;
  localparam logic [2:0] S_STALLED = 3'd4;

  localparam logic [31:0] L_TIMEOUT_AT = 32'(MAX_CYCLES - 1);

  if (MAX_CYCLES < 1 || STALL_LIMIT < 1) begin : g_bad_params
    $error("retire_monitor: MAX_CYCLES and STALL_LIMIT must be >= 1");
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
  endfunction

  logic [2:0]  r_state;
  logic [31:0] r_cycle_count;
  logic [31:0] r_instret;
  logic [31:0] r_last_retire_pc;
  logic [4:0]  r_last_rd;
  logic [31:0] r_last_data;
  logic        r_done;

  wire w_active  = (r_state == S_RUN) && en;
  wire w_halt    = (if_pc == HALT_PC);
  wire w_timeout = (r_cycle_count == L_TIMEOUT_AT);
  wire w_stall_hit;

`ifdef RETIRE_MON_STALL_WDT_EN
  localparam logic [31:0] L_STALL_AT = 32'(STALL_LIMIT - 1);

  logic [31:0] r_stall_cnt;
  logic [31:0] r_prev_pc;

  // A cycle is stalled when fetch has not moved and nothing retired.
  wire w_stall_cyc = (if_pc == r_prev_pc) && !retire_valid;
  assign w_stall_hit = w_stall_cyc && (r_stall_cnt == L_STALL_AT);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_stall_cnt <= 32'd0;
      r_prev_pc   <= 32'd0;
    end else if (r_state == S_IDLE && en) begin
      r_prev_pc <= if_pc;
    end else if (w_active) begin
      r_stall_cnt <= w_stall_cyc ? sat_inc(r_stall_cnt) : 32'd0;
      r_prev_pc   <= if_pc;
    end
  end
`else
  assign w_stall_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_state          <= S_IDLE;
      r_cycle_count    <= 32'd0;
      r_instret        <= 32'd0;
      r_last_retire_pc <= 32'd0;
      r_last_rd        <= 5'd0;
      r_last_data      <= 32'd0;
      r_done           <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_active) begin
            r_cycle_count <= sat_inc(r_cycle_count);
            if (retire_valid) begin
              r_instret        <= sat_inc(r_instret);
              r_last_retire_pc <= retire_pc;
              if (retire_we && retire_rd != 5'd0) begin
                r_last_rd   <= retire_rd;
                r_last_data <= retire_data;
              end
            end
            // Terminal checks use pre-increment counts; halt outranks stall outranks timeout.
            if (w_halt) begin
              r_state <= S_HALTED;
              r_done  <= 1'b1;
            end else if (w_stall_hit) begin
              r_state <= S_STALLED;
              r_done  <= 1'b1;
            end else if (w_timeout) begin
              r_state <= S_TIMEOUT;
              r_done  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign state          = r_state;
  assign cycle_count    = r_cycle_count;
  assign instret        = r_instret;
  assign last_retire_pc = r_last_retire_pc;
  assign last_rd        = r_last_rd;
  assign last_data      = r_last_data;
  assign done           = r_done;

endmodule

// File: tb/tb_retire_monitor.sv
// tb/tb_retire_monitor.sv - randomized and directed bench for retire_monitor
module tb_retire_monitor;

  localparam logic [31:0] HALT = 32'h000A00BC;
  localparam int MC = 20;
  localparam int SL = 5;
`ifdef RETIRE_MON_STALL_WDT_EN
  localparam bit WDT = 1'b1;
`else
  localparam bit WDT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, en, clr, retire_valid, retire_we;
  logic [31:0] if_pc, retire_pc, retire_data;
  logic [4:0]  retire_rd;
  logic [2:0]  state;
  logic [31:0] cycle_count, instret, last_retire_pc, last_data;
  logic [4:0]  last_rd;
  logic        done;

  always #5 clk = ~clk;

  retire_monitor #(.HALT_PC(HALT), .MAX_CYCLES(MC), .STALL_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .if_pc(if_pc),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_we(retire_we),
    .retire_rd(retire_rd), .retire_data(retire_data), .state(state),
    .cycle_count(cycle_count), .instret(instret), .last_retire_pc(last_retire_pc),
    .last_rd(last_rd), .last_data(last_data), .done(done)
  );

  int total = 0;
  int bad = 0;

  // Reference model: state 0 IDLE, 1 RUN, 2 HALTED, 3 TIMEOUT, 4 STALLED
  int              m_state;
  longint unsigned m_cyc, m_inst, m_stall;
  logic [31:0]     m_lpc, m_ldata, m_prev;
  logic [4:0]      m_lrd;
  bit              m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned sat(input longint unsigned v);
    return (v >= 64'hFFFFFFFF) ? 64'hFFFFFFFF : v + 1;
  endfunction

  task automatic model_step();
    bit stall_c;
    int nxt;
    if (!rst_n || clr) begin
      m_state = 0; m_cyc = 0; m_inst = 0; m_stall = 0;
      m_lpc = 0; m_ldata = 0; m_prev = 0; m_lrd = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (m_state == 0) begin
      if (en) begin
        m_state = 1;
        m_prev = if_pc;
      end
    end else if (m_state == 1 && en) begin
      stall_c = WDT && (if_pc == m_prev) && !retire_valid;
      nxt = 1;
      if (if_pc == HALT) nxt = 2;
      else if (stall_c && m_stall == SL - 1) nxt = 4;
      else if (m_cyc == MC - 1) nxt = 3;
      m_cyc = sat(m_cyc);
      if (retire_valid) begin
        m_inst = sat(m_inst);
        m_lpc = retire_pc;
        if (retire_we && retire_rd != 0) begin
          m_lrd = retire_rd;
          m_ldata = retire_data;
        end
      end
      m_stall = stall_c ? sat(m_stall) : 0;
      m_prev = if_pc;
      if (nxt != 1) begin
        m_state = nxt;
        m_done = 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("state", 32'(state), 32'(m_state));
    check("cycle_count", cycle_count, 32'(m_cyc));
    check("instret", instret, 32'(m_inst));
    check("last_retire_pc", last_retire_pc, m_lpc);
    check("last_rd", 32'(last_rd), 32'(m_lrd));
    check("last_data", last_data, m_ldata);
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic drive(input bit e, input logic [31:0] pc, input bit rv);
    rst_n = 1'b1; clr = 1'b0; en = e;
    if_pc = pc; retire_valid = rv; retire_pc = pc;
    retire_we = 1'($urandom); retire_rd = 5'($urandom); retire_data = $urandom;
    tick();
  endtask

  task automatic do_clr();
    rst_n = 1'b1; clr = 1'b1; en = 1'($urandom);
    if_pc = $urandom; retire_valid = 1'($urandom); retire_pc = $urandom;
    retire_we = 1'($urandom); retire_rd = 5'($urandom); retire_data = $urandom;
    tick();
  endtask

  task automatic run_hold(input logic [31:0] pc, input int pulse_at);
    for (int k = 1; k <= 40; k++) begin
      drive(1'b1, pc, k == pulse_at);
      if (state >= 3'd2) break;
    end
    check("hold_terminated", 32'(state >= 3'd2), 32'd1);
  endtask

  initial begin
    logic [31:0] pc;
    int r;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      rst_n = 1'b0; clr = 1'($urandom); en = 1'($urandom);
      if_pc = $urandom; retire_valid = 1'($urandom); retire_pc = $urandom;
      retire_we = 1'($urandom); retire_rd = 5'($urandom); retire_data = $urandom;
      tick();
      check("rst_state", 32'(state), 32'd0);
      check("rst_done", 32'(done), 32'd0);
    end

    // Halt
    drive(1'b1, 32'h0, 1'b0);
    drive(1'b1, 32'h0, 1'b1);
    drive(1'b1, 32'h4, 1'b1);
    drive(1'b1, 32'h8, 1'b1);
    drive(1'b1, HALT, 1'b0);
    check("halt_state", 32'(state), 32'd2);
    check("halt_cycles", cycle_count, 32'd4);
    check("halt_instret", instret, 32'd3);
    check("halt_lpc", last_retire_pc, 32'h8);
    check("halt_done", 32'(done), 32'd1);
    drive(1'b1, 32'h40, 1'b1);
    check("halt_done_once", 32'(done), 32'd0);
    check("halt_frozen", cycle_count, 32'd4);

    // Timeout
    do_clr();
    drive(1'b1, 32'h0, 1'b0);
    pc = 32'h0;
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, pc, 1'b1);
      pc += 32'd4;
      if (state >= 3'd2) break;
    end
    check("to_state", 32'(state), 32'd3);
    check("to_cycles", cycle_count, 32'd20);
    check("to_instret", instret, 32'd20);
    do_clr();
    check("clr_state", 32'(state), 32'd0);
    check("clr_cycles", cycle_count, 32'd0);
    check("clr_instret", instret, 32'd0);

    // Stall, plain and with a retire pulse on the third hold cycle
    drive(1'b1, 32'h0, 1'b0);
    run_hold(32'h40, 0);
    check("stall_state", 32'(state), WDT ? 32'd4 : 32'd3);
    check("stall_cycles", cycle_count, WDT ? 32'd6 : 32'd20);
    do_clr();
    drive(1'b1, 32'h0, 1'b0);
    run_hold(32'h40, 3);
    check("stall2_state", 32'(state), WDT ? 32'd4 : 32'd3);
    check("stall2_cycles", cycle_count, WDT ? 32'd8 : 32'd20);

    // Halt on the cycle the stall limit would be reached
    do_clr();
    drive(1'b1, 32'h0, 1'b0);
    for (int k = 0; k < 5; k++) drive(1'b1, 32'h40, 1'b0);
    drive(1'b1, HALT, 1'b0);
    check("prio_state", 32'(state), 32'd2);

    // Pause mid-run
    do_clr();
    drive(1'b1, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b1, 32'h40, 1'b0);
    for (int k = 0; k < 10; k++) drive(1'b0, 32'h40, 1'b0);
    check("pause_state", 32'(state), 32'd1);
    check("pause_cycles", cycle_count, 32'd3);
    drive(1'b1, 32'h40, 1'b0);
    check("resume_state", 32'(state), 32'd1);
    check("resume_cycles", cycle_count, 32'd4);

    // Randomized run against the model
    pc = 32'h100;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(99));
      if (r < 2 || (state >= 3'd2 && r < 30)) begin
        do_clr();
      end else if (r < 3) begin
        rst_n = 1'b0; clr = 1'($urandom); en = 1'($urandom); if_pc = $urandom;
        tick();
      end else begin
        if ($urandom_range(99) < 20) pc = 32'h100 + 32'($urandom_range(7)) * 32'd4;
        if ($urandom_range(199) == 0) pc = HALT;
        drive($urandom_range(7) != 0, pc, $urandom_range(3) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
